prt_dptx_sym_sched: RTL

PRT_DPTX_SYM_SCHED -- requirements
Module: prt_dptx_sym_sched

---
 rtl/prt_dptx_sym_sched_if.sv | 28 ++
 rtl/prt_dptx_sym_sched.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/prt_dptx_sym_sched_if.sv
// rtl/prt_dptx_sym_sched_if.sv - request and symbol bundle for the DP TX symbol scheduler
// Slave side is the scheduler; master side is the link-layer driver of requests.
interface prt_dptx_sym_sched_if #(
   parameter int P_SEC_LEN_W = 8
) ();
   logic                   CFG_EN_IN;
   logic                   CFG_EFM_IN;
   logic                   BS_REQ_IN;
   logic                   BE_REQ_IN;
   logic                   SEC_REQ_IN;
   logic [P_SEC_LEN_W-1:0] SEC_LEN_IN;
   logic                   SEC_ACK_OUT;
   logic                   SEC_RD_OUT;
   logic [4:0]             SYM_OUT;
   logic                   SYM_K_OUT;
   logic                   BLANK_OUT;
   logic                   ERR_OUT;

   modport slave (
      input  CFG_EN_IN, CFG_EFM_IN, BS_REQ_IN, BE_REQ_IN, SEC_REQ_IN, SEC_LEN_IN,
      output SEC_ACK_OUT, SEC_RD_OUT, SYM_OUT, SYM_K_OUT, BLANK_OUT, ERR_OUT
   );

   modport master (
      output CFG_EN_IN, CFG_EFM_IN, BS_REQ_IN, BE_REQ_IN, SEC_REQ_IN, SEC_LEN_IN,
      input  SEC_ACK_OUT, SEC_RD_OUT, SYM_OUT, SYM_K_OUT, BLANK_OUT, ERR_OUT
   );
endinterface

// File: rtl/prt_dptx_sym_sched.sv
// rtl/prt_dptx_sym_sched.sv - DP TX control symbol scheduler (BS/SR, BE, secondary SS/DAT/SE)
// Every output is a flop loaded from the next-state decode, so it lines up with the state it describes.
module prt_dptx_sym_sched #(
   parameter int P_SR_INTERVAL = 512,
   parameter int P_SEC_LEN_W   = 8
) (
   input logic                 CLK_IN,
   input logic                 RST_IN,
   prt_dptx_sym_sched_if.slave sif
);
   localparam int CW = ($clog2(P_SR_INTERVAL) > 9) ? $clog2(P_SR_INTERVAL) : 9;
   localparam logic [CW-1:0]          CNT_LAST = CW'(P_SR_INTERVAL - 1);
   localparam logic [P_SEC_LEN_W-1:0] LEN_ONE  = {{(P_SEC_LEN_W-1){1'b0}}, 1'b1};

   localparam logic [4:0] SYM_BS  = 5'd0;
   localparam logic [4:0] SYM_BE  = 5'd1;
   localparam logic [4:0] SYM_SS  = 5'd3;
   localparam logic [4:0] SYM_SE  = 5'd6;
   localparam logic [4:0] SYM_SR  = 5'd7;
   localparam logic [4:0] SYM_BF  = 5'd14;
   localparam logic [4:0] SYM_NOP = 5'd15;

   typedef enum logic [2:0] {IDLE, CTL, SS, DAT, SE} state_t;

   state_t                 state, nxt_state;
   logic [1:0]             idx, nxt_idx;
   logic                   efm_q, nxt_efm;
   logic                   sr_q, nxt_sr;
   logic                   be_seq_q, nxt_be_seq;
   logic [CW-1:0]          seq_cnt, nxt_cnt;
   logic [P_SEC_LEN_W-1:0] len_cnt, nxt_len;
   logic                   pend_bs, nxt_pend_bs;
   logic                   pend_be, nxt_pend_be;
   logic                   blank_q, nxt_blank;
   logic [4:0]             sym_q, nxt_sym;
   logic                   k_q, nxt_k;
   logic                   ack_q, nxt_ack;
   logic                   rd_q, nxt_rd;
   logic                   err_q, nxt_err;
   logic                   bs_req, be_req, bs_busy, be_busy, sec_ok, x_is_sr;

   always_ff @(posedge CLK_IN or posedge RST_IN) begin
      if (RST_IN) begin
         state    <= IDLE;
         idx      <= 2'd0;
         efm_q    <= 1'b0;
         sr_q     <= 1'b0;
         be_seq_q <= 1'b0;
         seq_cnt  <= '0;
         len_cnt  <= '0;
         pend_bs  <= 1'b0;
         pend_be  <= 1'b0;
         blank_q  <= 1'b0;
         sym_q    <= SYM_NOP;
         k_q      <= 1'b0;
         ack_q    <= 1'b0;
         rd_q     <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state    <= nxt_state;
         idx      <= nxt_idx;
         efm_q    <= nxt_efm;
         sr_q     <= nxt_sr;
         be_seq_q <= nxt_be_seq;
         seq_cnt  <= nxt_cnt;
         len_cnt  <= nxt_len;
         pend_bs  <= nxt_pend_bs;
         pend_be  <= nxt_pend_be;
         blank_q  <= nxt_blank;
         sym_q    <= nxt_sym;
         k_q      <= nxt_k;
         ack_q    <= nxt_ack;
         rd_q     <= nxt_rd;
         err_q    <= nxt_err;
      end
   end

   always_comb begin
      nxt_state   = state;
      nxt_idx     = idx;
      nxt_efm     = efm_q;
      nxt_sr      = sr_q;
      nxt_be_seq  = be_seq_q;
      nxt_cnt     = seq_cnt;
      nxt_len     = len_cnt;
      nxt_pend_bs = pend_bs;
      nxt_pend_be = pend_be;
      nxt_blank   = blank_q;
      nxt_sym     = SYM_NOP;
      nxt_k       = 1'b0;
      nxt_ack     = 1'b0;
      nxt_rd      = 1'b0;
      nxt_err     = 1'b0;
      bs_req      = sif.BS_REQ_IN;
      be_req      = sif.BE_REQ_IN;
      bs_busy     = (state == CTL) && !be_seq_q;
      be_busy     = (state == CTL) && be_seq_q;
      sec_ok      = blank_q && sif.SEC_REQ_IN && (sif.SEC_LEN_IN != '0) && !pend_bs && !pend_be;
      x_is_sr     = (seq_cnt == CNT_LAST);

      if (!sif.CFG_EN_IN) begin
         nxt_state   = IDLE;
         nxt_idx     = 2'd0;
         nxt_efm     = 1'b0;
         nxt_sr      = 1'b0;
         nxt_be_seq  = 1'b0;
         nxt_cnt     = '0;
         nxt_len     = '0;
         nxt_pend_bs = 1'b0;
         nxt_pend_be = 1'b0;
         nxt_blank   = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pend_bs) begin
                  nxt_state   = CTL;
                  nxt_idx     = 2'd0;
                  nxt_be_seq  = 1'b0;
                  nxt_efm     = sif.CFG_EFM_IN;
                  nxt_sr      = x_is_sr;
                  nxt_cnt     = x_is_sr ? '0 : seq_cnt + CW'(1);
                  nxt_pend_bs = 1'b0;
                  nxt_blank   = 1'b1;
                  nxt_sym     = x_is_sr ? SYM_SR : SYM_BS;
                  nxt_k       = 1'b1;
               end else if (pend_be) begin
                  nxt_state   = CTL;
                  nxt_idx     = 2'd0;
                  nxt_be_seq  = 1'b1;
                  nxt_pend_be = 1'b0;
                  nxt_blank   = 1'b0;
                  nxt_sym     = SYM_BE;
                  nxt_k       = 1'b1;
               end else if (sec_ok) begin
                  nxt_state = SS;
                  nxt_len   = sif.SEC_LEN_IN;
                  nxt_ack   = 1'b1;
                  nxt_sym   = SYM_SS;
                  nxt_k     = 1'b1;
               end
            end
            CTL: begin
               // Enhanced framing walks X,BF,BF,X; the closing X repeats the opening one.
               if (!be_seq_q && efm_q && idx != 2'd3) begin
                  nxt_idx = idx + 2'd1;
                  nxt_sym = (idx == 2'd2) ? (sr_q ? SYM_SR : SYM_BS) : SYM_BF;
                  nxt_k   = 1'b1;
               end else begin
                  nxt_state = IDLE;
                  nxt_idx   = 2'd0;
               end
            end
            SS: begin
               nxt_state = DAT;
               nxt_rd    = 1'b1;
            end
            DAT: begin
               if (len_cnt == LEN_ONE) begin
                  nxt_state = SE;
                  nxt_len   = '0;
                  nxt_sym   = SYM_SE;
                  nxt_k     = 1'b1;
               end else begin
                  nxt_len = len_cnt - LEN_ONE;
                  nxt_rd  = 1'b1;
               end
            end
            SE: nxt_state = IDLE;
            default: nxt_state = IDLE;
         endcase

         // A request for the sequence already running counts as a duplicate, like a set pending flag.
         if (bs_req) begin
            if (pend_bs || bs_busy) nxt_err = 1'b1;
            else                    nxt_pend_bs = 1'b1;
         end
         if (be_req) begin
            if (pend_be || be_busy)                nxt_err = 1'b1;
            else if (!blank_q && !pend_bs && !bs_req) nxt_err = 1'b1;
            else                                   nxt_pend_be = 1'b1;
         end
         if (bs_req && be_req) nxt_err = 1'b1;
      end
   end

   assign sif.SYM_OUT     = sym_q;
   assign sif.SYM_K_OUT   = k_q;
   assign sif.BLANK_OUT   = blank_q;
   assign sif.SEC_ACK_OUT = ack_q;
   assign sif.SEC_RD_OUT  = rd_q;
   assign sif.ERR_OUT     = err_q;
endmodule
